// File: rtl/csi2_tx_packet_scheduler.sv
// CSI-2 TX packet scheduler: turns frame/line event pulses into ordered short/long
// packet requests with HS-enable sequencing. Optional macro: CSI_TX_FRAME_NUMBER_EN.
module csi2_tx_packet_scheduler #(
  parameter int unsigned WORD_COUNT      = 1610,
  parameter logic [5:0]  DATA_TYPE       = 6'h2B,
  parameter logic [1:0]  VIRTUAL_CHANNEL = 2'b00,
  parameter int unsigned TRAIL_CYCLES    = 4
) (
  input  logic        clock_camera_byte,
  input  logic        reset_camera_byte,
  input  logic        fv_start_in,
  input  logic        fv_end_in,
  input  logic        lv_start_in,
  input  logic        byte_data_en_in,
  input  logic        c2d_ready_in,
  input  logic        d_hs_rdy_in,
  input  logic        error_clear_in,
  output logic        hs_en_out,
  output logic        sp_en_out,
  output logic        lp_en_out,
  output logic [5:0]  dt_out,
  output logic [15:0] wc_out,
  output logic [1:0]  vc_out,
  output logic        txfr_en_out,
  output logic        busy_out,
  output logic [15:0] frame_count_out,
  output logic [15:0] line_count_out,
  output logic        error_overflow_out,
  output logic        error_spurious_out
);

  localparam logic [1:0] EV_FS = 2'd1;
  localparam logic [1:0] EV_LS = 2'd2;
  localparam logic [1:0] EV_FE = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_HS_REQ, S_HEADER, S_PAYLOAD, S_TRAIL} state_t;
  state_t r_state, w_next;

  logic [1:0]  r_fifo [4];
  logic [1:0]  r_wr_ptr, r_rd_ptr;
  logic [2:0]  r_count;
  logic [1:0]  r_cur;
  logic [5:0]  r_dt;
  logic [15:0] r_wc;
  logic [15:0] r_byte_cnt;
  logic [15:0] r_trail_cnt;
  logic [15:0] r_line_cnt, r_line_total, r_frame_cnt;
  logic        r_err_ovf, r_err_spur;

  logic [1:0]  w_ev_code, w_head;
  logic        w_ev_any, w_ev_multi, w_full, w_push, w_pop, w_ovf, w_spur;
  logic [15:0] w_fs_wc, w_fe_wc;

  assign w_head = r_fifo[r_rd_ptr];

  // Event arbitration: FE beats FS beats LS; every losing or blocked pulse is an overflow
  always_comb begin
    w_ev_code = EV_LS;
    if (fv_end_in)        w_ev_code = EV_FE;
    else if (fv_start_in) w_ev_code = EV_FS;
    w_ev_any   = fv_end_in | fv_start_in | lv_start_in;
    w_ev_multi = (fv_end_in & fv_start_in) | (fv_end_in & lv_start_in) |
                 (fv_start_in & lv_start_in);
    w_full     = (r_count == 3'd4);
    w_push     = w_ev_any & ~w_full;
    w_ovf      = w_ev_multi | (w_ev_any & w_full);
    w_pop      = (r_state == S_IDLE) && (r_count != 3'd0);
    w_spur     = byte_data_en_in && (r_state != S_PAYLOAD);
  end

  always_ff @(posedge clock_camera_byte) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_ev_code;
  end

`ifdef CSI_TX_FRAME_NUMBER_EN
  logic [15:0] r_frame_num;

  function automatic logic [15:0] next_frame_num(input logic [15:0] cur);
    return (cur == 16'hFFFF) ? 16'd1 : cur + 16'd1;
  endfunction

  always_ff @(posedge clock_camera_byte) begin
    if (reset_camera_byte)               r_frame_num <= '0;
    else if (w_pop && w_head == EV_FS)   r_frame_num <= next_frame_num(r_frame_num);
  end

  assign w_fs_wc = next_frame_num(r_frame_num);
  assign w_fe_wc = r_frame_num;
`else
  assign w_fs_wc = '0;
  assign w_fe_wc = '0;
`endif

  always_comb begin
    w_next      = r_state;
    hs_en_out   = 1'b0;
    sp_en_out   = 1'b0;
    lp_en_out   = 1'b0;
    txfr_en_out = 1'b0;
    case (r_state)
      S_IDLE: if (w_pop) w_next = S_HS_REQ;
      S_HS_REQ: begin
        hs_en_out = 1'b1;
        if (c2d_ready_in && d_hs_rdy_in) w_next = S_HEADER;
      end
      S_HEADER: begin
        hs_en_out = 1'b1;
        sp_en_out = (r_cur != EV_LS);
        lp_en_out = (r_cur == EV_LS);
        w_next    = (r_cur == EV_LS) ? S_PAYLOAD : S_TRAIL;
      end
      S_PAYLOAD: begin
        hs_en_out   = 1'b1;
        txfr_en_out = 1'b1;
        if (byte_data_en_in && r_byte_cnt == 16'(WORD_COUNT - 1)) w_next = S_TRAIL;
      end
      S_TRAIL: begin
        hs_en_out = 1'b1;
        if (r_trail_cnt == 16'(TRAIL_CYCLES - 1)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_camera_byte) begin
    if (reset_camera_byte) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_cur        <= '0;
      r_dt         <= '0;
      r_wc         <= '0;
      r_byte_cnt   <= '0;
      r_trail_cnt  <= '0;
      r_line_cnt   <= '0;
      r_line_total <= '0;
      r_frame_cnt  <= '0;
      r_err_ovf    <= 1'b0;
      r_err_spur   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_count <= r_count + {2'b0, w_push} - {2'b0, w_pop};
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      // Dispatch: latch packet fields and update frame/line bookkeeping
      if (w_pop) begin
        r_cur    <= w_head;
        r_rd_ptr <= r_rd_ptr + 2'd1;
        case (w_head)
          EV_FS: begin
            r_dt        <= 6'h00;
            r_wc        <= w_fs_wc;
            r_line_cnt  <= '0;
            r_frame_cnt <= r_frame_cnt + 16'd1;
          end
          EV_FE: begin
            r_dt         <= 6'h01;
            r_wc         <= w_fe_wc;
            r_line_total <= r_line_cnt;
          end
          default: begin
            r_dt       <= DATA_TYPE;
            r_wc       <= 16'(WORD_COUNT);
            r_line_cnt <= r_line_cnt + 16'd1;
          end
        endcase
      end
      if (r_state != S_PAYLOAD)  r_byte_cnt <= '0;
      else if (byte_data_en_in)  r_byte_cnt <= r_byte_cnt + 16'd1;
      if (r_state != S_TRAIL)    r_trail_cnt <= '0;
      else                       r_trail_cnt <= r_trail_cnt + 16'd1;
      // A new error in the same cycle as a clear keeps the flag set
      r_err_ovf  <= w_ovf  | (r_err_ovf  & ~error_clear_in);
      r_err_spur <= w_spur | (r_err_spur & ~error_clear_in);
    end
  end

  assign dt_out             = r_dt;
  assign wc_out             = r_wc;
  assign vc_out             = VIRTUAL_CHANNEL;
  assign busy_out           = (r_state != S_IDLE) || (r_count != 3'd0);
  assign frame_count_out    = r_frame_cnt;
  assign line_count_out     = r_line_total;
  assign error_overflow_out = r_err_ovf;
  assign error_spurious_out = r_err_spur;

endmodule
